// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, decode and the branch unit.
// master = fetch_unit side, slave = environment side.
interface fetch_unit_if;
    logic [31:0] imemAddr;
    logic [31:0] imemInstr;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstr;
    logic [31:0] outPc;
    logic        redirectValid;
    logic [31:0] redirectTarget;

    modport master (
        output imemAddr, outValid, outInstr, outPc,
        input  imemInstr, outReady, redirectValid, redirectTarget
    );

    modport slave (
        input  imemAddr, outValid, outInstr, outPc,
        output imemInstr, outReady, redirectValid, redirectTarget
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-entry IF/ID register, redirect, halt-on-zero and fetch counter.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky FAULT state for misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 16,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] fetchCount,
    fetch_unit_if.master         fio
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
        ,FAULT = 2'd3
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_instr_q, out_instr_d;
    logic [31:0]           out_pc_q, out_pc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic                  accept;
    logic                  slot_free;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  unused_target_bits;

    assign accept      = out_valid_q && fio.outReady;
    assign slot_free   = !out_valid_q || fio.outReady;
    assign redirect_pc = {fio.redirectTarget[ADDR_WIDTH-1:2], 2'b00};

    // Bits above the memory window and the forced-zero low bits never reach the PC.
    assign unused_target_bits = ^{fio.redirectTarget[31:ADDR_WIDTH], fio.redirectTarget[1:0]};

    always_comb begin
        // NOTE: every target gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        count_d     = count_q;

        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (start) state_d = RUN;
            end

            RUN, HALT: begin
                if (fio.redirectValid) begin
                    out_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (fio.redirectTarget[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = RUN;
                    end
`else
                    pc_d    = redirect_pc;
                    state_d = RUN;
`endif
                end else if (state_q == RUN && slot_free) begin
                    if (fio.imemInstr != 32'd0) begin
                        out_instr_d = fio.imemInstr;
                        out_pc_d    = 32'(pc_q);
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + ADDR_WIDTH'(4);
                        if (count_q != '1) count_d = count_q + CNT_WIDTH'(1);
                    end else begin
                        // Zero word ends the stream; a word accepted this cycle still drains.
                        state_d = HALT;
                        if (accept) out_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    out_valid_d = 1'b0;
                end
            end

`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: begin
                out_valid_d = 1'b0;
            end
`endif

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC[ADDR_WIDTH-1:0];
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 32'd0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            count_q     <= count_d;
        end
    end

    assign fio.imemAddr = 32'(pc_q);
    assign fio.outValid = out_valid_q;
    assign fio.outInstr = out_instr_q;
    assign fio.outPc    = out_pc_q;
    assign halted       = (state_q == HALT);
    assign fetchCount   = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fault        = (state_q == FAULT);
`else
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stalls, redirects, halt, PC wrap and alignment handling.
// Expected values are hand-computed for RESET_PC=0, ADDR_WIDTH=16, CNT_WIDTH=32.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halted;
    logic        fault;
    logic [31:0] fetchCount;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:16383];

    fetch_unit_if fio ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (16),
        .CNT_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halted     (halted),
        .fault      (fault),
        .fetchCount (fetchCount),
        .fio        (fio.master)
    );

    always #5 clk = ~clk;

    assign fio.imemInstr = mem[fio.imemAddr[15:2]];

    localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002, WC = 32'hC000_0003;
    localparam logic [31:0] WD = 32'hD000_0004, WE = 32'hE000_0005, WF = 32'hF000_0006;
    localparam logic [31:0] WG = 32'h1234_5678, WH = 32'h0BAD_F00D, WI = 32'h0000_0013;
    localparam logic [31:0] WJ = 32'h7777_0001, WL = 32'h5555_AAAA, WM = 32'h6666_BBBB;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        fio.redirectValid  = 1'b1;
        fio.redirectTarget = target;
        tick();
        fio.redirectValid  = 1'b0;
        fio.redirectTarget = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        mem[0]     = WA;  mem[1]     = WB;  mem[2]  = WC;
        mem[16]    = WD;  mem[17]    = WE;  mem[18] = WF;  mem[19] = WG;
        mem[64]    = WH;  mem[65]    = WI;
        mem[128]   = WJ;
        mem[16382] = WL;  mem[16383] = WM;

        rst                = 1'b1;
        start              = 1'b0;
        fio.outReady       = 1'b1;
        fio.redirectValid  = 1'b0;
        fio.redirectTarget = 32'd0;
        tick();
        tick();

        check("rst_valid", 32'(fio.outValid), 32'd0);
        check("rst_instr", fio.outInstr, 32'd0);
        check("rst_pc", fio.outPc, 32'd0);
        check("rst_addr", fio.imemAddr, 32'd0);
        check("rst_count", fetchCount, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;

        // Stream A,B,C then halt on the zero word at 0xC.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_run_novalid", 32'(fio.outValid), 32'd0);
        check("t1_run_addr", fio.imemAddr, 32'd0);
        tick();
        check("t1_A_instr", fio.outInstr, WA);
        check("t1_A_pc", fio.outPc, 32'h0);
        tick();
        check("t1_B_instr", fio.outInstr, WB);
        check("t1_B_pc", fio.outPc, 32'h4);
        tick();
        check("t1_C_instr", fio.outInstr, WC);
        check("t1_C_pc", fio.outPc, 32'h8);
        tick();
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_drained", 32'(fio.outValid), 32'd0);
        check("t1_pc_held", fio.imemAddr, 32'hC);
        check("t1_count", fetchCount, 32'd3);

        // Start in HALT has no effect.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_start_ign_halt", 32'(halted), 32'd1);
        check("t4_start_ign_pc", fio.imemAddr, 32'hC);

        // Redirect out of HALT to 0x40, then stall with outReady low for 3 cycles.
        redirect_to(32'h40);
        check("t4_redir_run", 32'(halted), 32'd0);
        check("t4_redir_addr", fio.imemAddr, 32'h40);
        check("t4_redir_novalid", 32'(fio.outValid), 32'd0);
        tick();
        check("t4_D_instr", fio.outInstr, WD);
        check("t4_D_pc", fio.outPc, 32'h40);
        check("t4_D_count", fetchCount, 32'd4);
        fio.outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_stall_valid", 32'(fio.outValid), 32'd1);
            check("t2_stall_instr", fio.outInstr, WD);
            check("t2_stall_pc", fio.outPc, 32'h40);
            check("t2_stall_addr", fio.imemAddr, 32'h44);
        end
        fio.outReady = 1'b1;
        tick();
        check("t2_E_instr", fio.outInstr, WE);
        check("t2_E_pc", fio.outPc, 32'h44);
        tick();
        check("t2_F_pc", fio.outPc, 32'h48);
        tick();
        check("t2_G_instr", fio.outInstr, WG);
        tick();
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_count", fetchCount, 32'd7);

        // Redirect while a word is held and not accepted: it is flushed, not counted.
        redirect_to(32'h200);
        tick();
        check("t3_J_instr", fio.outInstr, WJ);
        check("t3_J_count", fetchCount, 32'd8);
        fio.outReady = 1'b0;
        redirect_to(32'h100);
        check("t3_flush_valid", 32'(fio.outValid), 32'd0);
        check("t3_flush_addr", fio.imemAddr, 32'h100);
        check("t3_flush_count", fetchCount, 32'd8);
        fio.outReady = 1'b1;
        tick();
        check("t3_H_pc", fio.outPc, 32'h100);
        check("t3_H_instr", fio.outInstr, WH);
        check("t3_H_count", fetchCount, 32'd9);
        tick();
        tick();
        check("t3_halted", 32'(halted), 32'd1);
        check("t3_count", fetchCount, 32'd10);

        // PC wrap at the top of the 64 KB window.
        redirect_to(32'hFFF8);
        tick();
        check("t5_pc_fff8", fio.outPc, 32'hFFF8);
        check("t5_L_instr", fio.outInstr, WL);
        tick();
        check("t5_pc_fffc", fio.outPc, 32'hFFFC);
        tick();
        check("t5_pc_wrap", fio.outPc, 32'h0);
        check("t5_wrap_instr", fio.outInstr, WA);
        check("t5_wrap_addr", fio.imemAddr, 32'h4);
        tick();
        tick();
        tick();
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_count", fetchCount, 32'd15);

        // Misaligned redirect target.
        redirect_to(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_fault", 32'(fault), 32'd1);
        check("t6_fault_novalid", 32'(fio.outValid), 32'd0);
        check("t6_fault_pc", fio.imemAddr, 32'hC);
        redirect_to(32'h40);
        tick();
        check("t6_fault_sticky", 32'(fault), 32'd1);
        check("t6_fault_count", fetchCount, 32'd15);
        check("t6_fault_hold_valid", 32'(fio.outValid), 32'd0);
`else
        check("t6_nofault", 32'(fault), 32'd0);
        check("t6_align_addr", fio.imemAddr, 32'h100);
        tick();
        check("t6_H_pc", fio.outPc, 32'h100);
        check("t6_H_instr", fio.outInstr, WH);
        check("t6_count", fetchCount, 32'd16);
`endif

        // Reset overrides a simultaneous redirect.
        rst                = 1'b1;
        fio.redirectValid  = 1'b1;
        fio.redirectTarget = 32'h200;
        tick();
        fio.redirectValid  = 1'b0;
        rst                = 1'b0;
        check("rst2_addr", fio.imemAddr, 32'h0);
        check("rst2_valid", 32'(fio.outValid), 32'd0);
        check("rst2_count", fetchCount, 32'd0);
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_fault", 32'(fault), 32'd0);

        // Back in IDLE a redirect is ignored.
        redirect_to(32'h40);
        check("idle_redir_ign", fio.imemAddr, 32'h0);
        check("idle_novalid", 32'(fio.outValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
